control_fsm_param: RTL
======================

// Module: control_fsm_param
// PURPOSE
//   Parametrised multi-cycle control unit for the accumulator-style processor datapath.
//   Owns its own 4-state sequencer instead of taking the cycle number from an external counter.
//   Latches the instruction on a run/done handshake, decodes opcode and register fields,
//   and drives Reg A / Reg R enables, ALU op, operand muxes, the one-hot register-file write mask and the bus enable.
//   Sits between the instruction source (switches/ROM) and the datapath (register file, ALU, bus mux).
// PARAMETERS
//   INSTR_W     16  instruction width; must be >= 3 + 2*REG_ADDR_W
//   REG_ADDR_W  3   register address width; NUM_REGS = 2**REG_ADDR_W
//   COUNT_W     16  width of instr_count (used only with CTRL_INSTR_COUNT_EN)
// PORTS
//   clock              in   1            system clock, rising edge
//   reset              in   1            asynchronous, active-high reset
//   run                in   1            request to execute instruction (sampled in IDLE and WRITE)
//   instruction        in   INSTR_W      [INSTR_W-1 -: 3]=opcode, next REG_ADDR_W=Rx, next REG_ADDR_W=Ry
//   busy               out  1            1 when state != IDLE
//   done               out  1            1-cycle pulse in WRITE state (instruction retired)
//   illegal_opcode     out  1            1-cycle pulse when an undefined opcode is rejected
//   reg_a_enable       out  1            load Reg A
//   reg_r_enable       out  1            load Reg R
//   reg_write_mask     out  2**REG_ADDR_W  one-hot register-file write enable
//   alu_op_code        out  3            ALU operation
//   mux_sel_op_a       out  1            0=Rx, 1=immediate into Reg A
//   mux_sel_op_b       out  1            0=Ry, 1=immediate into ALU B
//   bus_mux_select     out  1            0=Rx, 1=Reg R onto bus
//   reg_read_addr_x    out  REG_ADDR_W   Rx read address
//   reg_read_addr_y    out  REG_ADDR_W   Ry read address
//   bus_output_enable  out  1            drive bus (OUT, WRITE state)
//   instr_count        out  COUNT_W      retired-instruction count (CTRL_INSTR_COUNT_EN only)
// BEHAVIOUR
//   Opcodes: ADD=000 SUB=001 NAN=010 OUT=100 LDI=101 REP=111; 011 and 110 are illegal.
//   ALU codes: ADD=000 SUB=001 NAN=010 PASS_A=011 PASS_B=100.
//   State register: IDLE -> LOAD_A -> EXEC -> WRITE -> IDLE. All outputs decoded from state + latched IR (no input-to-output path).
//   IDLE: run=1 with legal opcode -> latch instruction into IR, go LOAD_A. Illegal opcode -> stay IDLE, IR unchanged, illegal_opcode=1 next cycle for 1 cycle.
//   LOAD_A: reg_a_enable=1; mux_sel_op_a=1 for LDI, else 0.
//   EXEC: reg_r_enable=1; ADD/SUB/NAN -> matching ALU code, op_b=0; LDI -> PASS_B, op_b=1; REP -> PASS_B, op_b=0; OUT -> PASS_A, op_b=0.
//   WRITE: done=1; ADD/SUB/NAN/LDI/REP -> reg_write_mask = 1<<Rx; OUT -> bus_output_enable=1, bus_mux_select=1 (Reg R), mask=0.
//   WRITE + run=1 (legal): latch new IR, go straight to LOAD_A (back-to-back, 3-cycle throughput). Illegal -> IDLE + illegal pulse.
//   run in LOAD_A/EXEC ignored; instruction input changes after acceptance have no effect.
//   Latency: run accepted at edge k -> LOAD_A cycle k+1, EXEC k+2, WRITE/done k+3.
//   reg_read_addr_x/y = IR fields in every state (stable for whole instruction).
//   Outside their state, enables, mask, bus_output_enable, mux selects = 0; alu_op_code = ADD.
//   Reset (any time, incl. mid-instruction): state=IDLE, IR=0, all outputs 0, alu_op_code=000; no partial write completes.
// CONFIGURATION
//   CTRL_INSTR_COUNT_EN defined: instr_count increments on each done pulse, saturates at all-ones, reset to 0;
//     illegal rejects not counted.
//   Not defined: instr_count tied to 0, counter logic absent.
// TESTING
//   reset; run=1, LDI R3 (instr 16'hAC00) -> LOAD_A op_a=1; EXEC alu=100 op_b=1; WRITE mask=8'h08, done=1.
//   ADD R1,R2 (16'h0500) -> EXEC alu=000 op_b=0, read_x=1 read_y=2; WRITE mask=8'h02.
//   OUT R5 (16'h9400) -> WRITE bus_output_enable=1, bus_mux_select=1, mask=0, done=1.
//   opcode 011 with run=1 in IDLE -> illegal_opcode pulse 1 cycle, busy stays 0, no enables.
//   run held high over ADD then SUB -> second LOAD_A immediately after first WRITE; done every 3 cycles.
//   reset asserted during EXEC -> next cycle IDLE, reg_r_enable=0, mask=0; with CTRL_INSTR_COUNT_EN, 4 instrs -> instr_count=4.

Source files
------------

// File: rtl/control_fsm_param_if.sv
// Handshake and datapath-control bundle for control_fsm_param.
// master: instruction source (drives run/instruction, observes status and controls).
// slave : the control unit itself.
interface control_fsm_param_if #(
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3,
  parameter int COUNT_W    = 16
);
  logic                       run;
  logic [INSTR_W-1:0]         instruction;
  logic                       busy;
  logic                       done;
  logic                       illegal_opcode;
  logic                       reg_a_enable;
  logic                       reg_r_enable;
  logic [2**REG_ADDR_W-1:0]   reg_write_mask;
  logic [2:0]                 alu_op_code;
  logic                       mux_sel_op_a;
  logic                       mux_sel_op_b;
  logic                       bus_mux_select;
  logic [REG_ADDR_W-1:0]      reg_read_addr_x;
  logic [REG_ADDR_W-1:0]      reg_read_addr_y;
  logic                       bus_output_enable;
  logic [COUNT_W-1:0]         instr_count;

  modport master (
    output run, instruction,
    input  busy, done, illegal_opcode, reg_a_enable, reg_r_enable,
           reg_write_mask, alu_op_code, mux_sel_op_a, mux_sel_op_b,
           bus_mux_select, reg_read_addr_x, reg_read_addr_y,
           bus_output_enable, instr_count
  );

  modport slave (
    input  run, instruction,
    output busy, done, illegal_opcode, reg_a_enable, reg_r_enable,
           reg_write_mask, alu_op_code, mux_sel_op_a, mux_sel_op_b,
           bus_mux_select, reg_read_addr_x, reg_read_addr_y,
           bus_output_enable, instr_count
  );
endinterface

// File: rtl/control_fsm_param.sv
// control_fsm_param: multi-cycle control unit for the accumulator datapath.
// Sequence IDLE -> LOAD_A -> EXEC -> WRITE, back-to-back from WRITE when run is held.
// All control outputs are registered and decoded from the next state and next IR,
// so nothing combinational reaches the outputs from run/instruction.
// Optional feature macro: CTRL_INSTR_COUNT_EN (saturating retired-instruction counter).
// INSTR_W must be >= 3 + 2*REG_ADDR_W; bits below the Ry field are ignored.
module control_fsm_param #(
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3,
  parameter int COUNT_W    = 16
) (
  input logic                 clock,
  input logic                 reset,
  control_fsm_param_if.slave  bus
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int FIELD_W  = 3 + 2*REG_ADDR_W;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NAN = 3'b010;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_REP = 3'b111;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_PASS_A = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_A = 2'd1,
    S_EXEC   = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  // Only opcode/Rx/Ry are kept; the IR holds exactly the decoded fields.
  logic [FIELD_W-1:0] in_fields;
  logic [2:0]         in_op;
  logic               in_legal;

  assign in_fields = bus.instruction[INSTR_W-1 -: FIELD_W];
  assign in_op     = in_fields[FIELD_W-1 -: 3];
  assign in_legal  = (in_op != 3'b011) && (in_op != 3'b110);

  generate
    if (INSTR_W > FIELD_W) begin : g_spare
      logic unused_spare_bits;
      assign unused_spare_bits = ^bus.instruction[INSTR_W-FIELD_W-1:0];
    end
  endgenerate

  state_t                  state_reg, state_next;
  logic [FIELD_W-1:0]      ir_reg, ir_next;
  logic                    illegal_next;

  logic                    busy_reg;
  logic                    done_reg, done_next;
  logic                    illegal_reg;
  logic                    a_en_reg, a_en_next;
  logic                    r_en_reg, r_en_next;
  logic [NUM_REGS-1:0]     mask_reg, mask_next;
  logic [2:0]              alu_reg, alu_next;
  logic                    op_a_reg, op_a_next;
  logic                    op_b_reg, op_b_next;
  logic                    bus_sel_reg, bus_sel_next;
  logic                    bus_oe_reg, bus_oe_next;

  logic [2:0]              op_n;
  logic [REG_ADDR_W-1:0]   rx_n;

  assign op_n = ir_next[FIELD_W-1 -: 3];
  assign rx_n = ir_next[FIELD_W-4 -: REG_ADDR_W];

  // Next state / IR: run is only honoured in IDLE and WRITE; illegal opcodes fall back to IDLE.
  always_comb begin
    state_next   = state_reg;
    ir_next      = ir_reg;
    illegal_next = 1'b0;
    case (state_reg)
      S_IDLE, S_WRITE: begin
        state_next = S_IDLE;
        if (bus.run) begin
          if (in_legal) begin
            ir_next    = in_fields;
            state_next = S_LOAD_A;
          end else begin
            illegal_next = 1'b1;
          end
        end
      end
      S_LOAD_A: state_next = S_EXEC;
      S_EXEC:   state_next = S_WRITE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Control decode for the cycle that follows the coming edge.
  always_comb begin
    done_next    = 1'b0;
    a_en_next    = 1'b0;
    r_en_next    = 1'b0;
    mask_next    = '0;
    alu_next     = ALU_ADD;
    op_a_next    = 1'b0;
    op_b_next    = 1'b0;
    bus_sel_next = 1'b0;
    bus_oe_next  = 1'b0;
    case (state_next)
      S_LOAD_A: begin
        a_en_next = 1'b1;
        op_a_next = (op_n == OP_LDI);
      end
      S_EXEC: begin
        r_en_next = 1'b1;
        case (op_n)
          OP_ADD, OP_SUB, OP_NAN: alu_next = op_n;
          OP_LDI: begin
            alu_next  = ALU_PASS_B;
            op_b_next = 1'b1;
          end
          OP_REP:  alu_next = ALU_PASS_B;
          OP_OUT:  alu_next = ALU_PASS_A;
          default: alu_next = ALU_ADD;
        endcase
      end
      S_WRITE: begin
        done_next = 1'b1;
        if (op_n == OP_OUT) begin
          bus_oe_next  = 1'b1;
          bus_sel_next = 1'b1;
        end else begin
          mask_next[rx_n] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer state, IR and registered control outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      ir_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      a_en_reg    <= 1'b0;
      r_en_reg    <= 1'b0;
      mask_reg    <= '0;
      alu_reg     <= ALU_ADD;
      op_a_reg    <= 1'b0;
      op_b_reg    <= 1'b0;
      bus_sel_reg <= 1'b0;
      bus_oe_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ir_reg      <= ir_next;
      busy_reg    <= (state_next != S_IDLE);
      done_reg    <= done_next;
      illegal_reg <= illegal_next;
      a_en_reg    <= a_en_next;
      r_en_reg    <= r_en_next;
      mask_reg    <= mask_next;
      alu_reg     <= alu_next;
      op_a_reg    <= op_a_next;
      op_b_reg    <= op_b_next;
      bus_sel_reg <= bus_sel_next;
      bus_oe_reg  <= bus_oe_next;
    end
  end

  assign bus.busy              = busy_reg;
  assign bus.done              = done_reg;
  assign bus.illegal_opcode    = illegal_reg;
  assign bus.reg_a_enable      = a_en_reg;
  assign bus.reg_r_enable      = r_en_reg;
  assign bus.reg_write_mask    = mask_reg;
  assign bus.alu_op_code       = alu_reg;
  assign bus.mux_sel_op_a      = op_a_reg;
  assign bus.mux_sel_op_b      = op_b_reg;
  assign bus.bus_mux_select    = bus_sel_reg;
  assign bus.bus_output_enable = bus_oe_reg;
  assign bus.reg_read_addr_x   = ir_reg[FIELD_W-4 -: REG_ADDR_W];
  assign bus.reg_read_addr_y   = ir_reg[REG_ADDR_W-1:0];

`ifdef CTRL_INSTR_COUNT_EN
  logic [COUNT_W-1:0] count_reg;

  // Retired-instruction counter: steps together with the done pulse, sticks at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if ((state_next == S_WRITE) && (count_reg != {COUNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign bus.instr_count = count_reg;
`else
  assign bus.instr_count = {COUNT_W{1'b0}};
`endif
endmodule
